// File: rtl/bin2dec_pkg.sv
// Shared constants for the binary-to-decimal display converter:
// segment codes (bit 6..0), FSM states and the overflow-limit helper.
package bin2dec_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0011000;
  localparam logic [6:0] SEG_2     = 7'b1110110;
  localparam logic [6:0] SEG_3     = 7'b1111100;
  localparam logic [6:0] SEG_4     = 7'b1011001;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1101111;
  localparam logic [6:0] SEG_7     = 7'b0111000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111101;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  // 10^n in 40 bits; 10^10 needs 34 bits, so DIGITS up to 10 is exact.
  function automatic logic [39:0] pow10(input int n);
    logic [39:0] r;
    r = 40'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 40'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD nibble to 7-segment encoder; non-decimal nibbles go blank.
module seg7_enc
  import bin2dec_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Digit lookup.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2dec_seg_conv.sv
// Sequential double-dabble binary-to-BCD converter with per-digit 7-segment output.
// Optional leading-zero blanking of the segment outputs: define BIN2DEC_LZ_BLANK_EN.
module bin2dec_seg_conv
  import bin2dec_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [7*DIGITS-1:0]   out_seg,
  output logic                  out_ovf
);

  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [39:0]       LIMIT = pow10(DIGITS) - 40'd1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_bin;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf;
  logic                  r_out_valid;
  logic [4*DIGITS-1:0]   r_out_bcd;
  logic [7*DIGITS-1:0]   r_out_seg;
  logic                  r_out_ovf;

  logic                  w_accept;
  logic                  w_last;
  logic [4*DIGITS-1:0]   w_bcd_adj;
  logic [4*DIGITS-1:0]   w_bcd_shift;
  logic [4*DIGITS-1:0]   w_bcd_res;
  logic [7*DIGITS-1:0]   w_seg_raw;
  logic [7*DIGITS-1:0]   w_seg_res;

  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == CONV) && (r_cnt == LAST);

  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign out_seg   = r_out_seg;
  assign out_ovf   = r_out_ovf;

  // The final shift result is encoded directly so outputs load on the CONV->OUT edge.
  assign w_bcd_shift = {w_bcd_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
  assign w_bcd_res   = r_ovf ? {DIGITS{4'h9}} : w_bcd_shift;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ?
                                   (r_bcd[4*g +: 4] + 4'd3) : r_bcd[4*g +: 4];

      seg7_enc u_enc (
        .i_bcd (w_bcd_res[4*g +: 4]),
        .o_seg (w_seg_raw[7*g +: 7])
      );

`ifdef BIN2DEC_LZ_BLANK_EN
      // A digit is blank when it and every digit above it is zero; units always show.
      if (g == 0) begin : g_units
        assign w_seg_res[6:0] = w_seg_raw[6:0];
      end else begin : g_upper
        assign w_seg_res[7*g +: 7] = (|w_bcd_res[4*DIGITS-1:4*g]) ?
                                     w_seg_raw[7*g +: 7] : SEG_BLANK;
      end
`else
      assign w_seg_res[7*g +: 7] = w_seg_raw[7*g +: 7];
`endif
    end
  endgenerate

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = CONV;
        else          w_state_nxt = IDLE;
      end
      CONV: begin
        if (r_cnt == LAST) w_state_nxt = OUT;
        else               w_state_nxt = CONV;
      end
      OUT: begin
        if (out_ready) w_state_nxt = IDLE;
        else           w_state_nxt = OUT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift/accumulate datapath.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_bin <= in_bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= ({{(40-WIDTH){1'b0}}, in_bin} > LIMIT);
    end else if (r_state == CONV) begin
      r_bin <= {r_bin[WIDTH-2:0], 1'b0};
      r_bcd <= w_bcd_shift;
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_bin <= r_bin;
      r_bcd <= r_bcd;
      r_cnt <= r_cnt;
      r_ovf <= r_ovf;
    end
  end

  // Output registers: load at end of conversion, hold until the next result.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_seg   <= {DIGITS{SEG_BLANK}};
      r_out_ovf   <= 1'b0;
    end else if (w_last) begin
      r_out_valid <= 1'b1;
      r_out_bcd   <= w_bcd_res;
      r_out_seg   <= w_seg_res;
      r_out_ovf   <= r_ovf;
    end else if ((r_state == OUT) && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

endmodule
